uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning the bits per word of every source and of the transmitter.
REQ-002 SHALL have parameter NUM_PORTS, default 4, meaning the number of source FIFOs (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning the most words sent from one source per grant (>=1).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port port_enable  input  NUM_PORTS  per-source arbitration enable.
REQ-007 SHALL have port src_empty  input  NUM_PORTS  per-source FIFO empty flag.
REQ-008 SHALL have port src_din  input  NUM_PORTS*WORD_WIDTH  per-source FIFO read data; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-009 SHALL have port src_re  output  NUM_PORTS  per-source FIFO read enable.
REQ-010 SHALL have port tx_re  input  1  read enable from the transmitter.
REQ-011 SHALL have port tx_empty  output  1  empty flag presented to the transmitter.
REQ-012 SHALL have port tx_din  output  WORD_WIDTH  data presented to the transmitter.
REQ-013 SHALL have port grant  output  NUM_PORTS  one-hot current grant, or all zero.
REQ-014 SHALL have port burst_count  output  $clog2(MAX_BURST+1)  words read in the current grant.

Function
REQ-015 SHALL implement an FSM with states ARB, GRANT and DATA.
REQ-016 Source FIFO read data SHALL be valid the cycle after its src_re; the transmitter SHALL sample tx_din the cycle after its tx_re.
REQ-017 Eligible port: port_enable[i]=1 and src_empty[i]=0.
REQ-018 ARB: grant=0, tx_empty=1, src_re=0; if any port is eligible, SHALL register the first eligible index found searching round-robin from ptr, set burst_count=0, and go to GRANT next cycle; otherwise SHALL stay in ARB.
REQ-019 ptr SHALL be the search start index; it SHALL reset to 0 and SHALL become (g+1) mod NUM_PORTS on every release of grant g.
REQ-020 GRANT: grant=onehot(g); tx_empty=src_empty[g] | ~port_enable[g]; src_re[g]=tx_re & ~tx_empty (combinational, same cycle); all other src_re SHALL be 0.
REQ-021 GRANT with tx_re & ~tx_empty: burst_count SHALL increment and the FSM SHALL go to DATA.
REQ-022 GRANT with tx_empty=1: the FSM SHALL release the grant (ptr update) and go to ARB the next cycle.
REQ-023 DATA: tx_empty=1, src_re=0, grant held, tx_din=src_din[g]; the FSM SHALL go to ARB with release if burst_count==MAX_BURST, else to GRANT.
REQ-024 tx_din SHALL be src_din[g] for the registered g in all states, and all zeros when no grant has occurred since reset.
REQ-025 tx_re asserted in ARB or DATA, or while tx_empty=1, SHALL be ignored: no src_re and no state or counter change.
REQ-026 Deasserting port_enable[g] while granted SHALL take effect in GRANT via tx_empty per REQ-020 and REQ-022; a read already issued SHALL complete through DATA.
REQ-027 A source that empties mid-burst SHALL lose the grant at its next GRANT cycle; words not yet written to it SHALL wait for a later round.
REQ-028 At most one src_re bit SHALL be high in any cycle, and src_re SHALL never be high while the selected src_empty is high.

Reset
REQ-029 With rst=1 at a rising edge: state=ARB, ptr=0, g=0, burst_count=0, grant=0, src_re=0, tx_empty=1, tx_din=0.
REQ-030 Reset SHALL take priority over every other event, including a read in flight; a word read from a source during the reset cycle is dropped and not replayed.

Verification
REQ-031 Only port 2 is non-empty with 3 words, all enabled -> grant=0100; three src_re[2] pulses, each aligned with a tx_re; release to ARB; ptr=3.
REQ-032 Ports 0 and 1 each hold 20 words, MAX_BURST=16 -> 16 words from port 0, then 16 from port 1, then 4 from port 0, then 4 from port 1; burst_count peaks at 16.
REQ-033 All ports non-empty, MAX_BURST=1 -> grant sequence 0,1,2,3,0,... with one word per grant.
REQ-034 port_enable=1011 with all ports non-empty -> port 2 is never granted; clearing port_enable[0] during port 0's GRANT state -> tx_empty=1 the same cycle and release the next cycle.
REQ-035 Spurious tx_re in ARB and in DATA -> no src_re, no burst_count change.
REQ-036 rst asserted in the cycle after a src_re pulse -> all outputs at reset values the next cycle; with all ports non-empty, arbitration resumes from port 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS source FIFOs into one transmitter FIFO interface,
// sending at most MAX_BURST words from a source before re-arbitrating.
module uart_tx_arbiter #(
   parameter int WORD_WIDTH = 8,
   parameter int NUM_PORTS  = 4,
   parameter int MAX_BURST  = 16,
   localparam int PTR_W     = $clog2(NUM_PORTS),
   localparam int BC_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            port_enable,
   input  logic [NUM_PORTS-1:0]            src_empty,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] src_din,
   output logic [NUM_PORTS-1:0]            src_re,
   input  logic                            tx_re,
   output logic                            tx_empty,
   output logic [WORD_WIDTH-1:0]           tx_din,
   output logic [NUM_PORTS-1:0]            grant,
   output logic [BC_W-1:0]                 burst_count,
   output logic [1:0]                      state_dbg
);

   // FIFO-style handshake on both sides: a read (re high while empty low) is accepted on the
   // rising edge, and the word it fetches is presented on the data lines during the next cycle.
   typedef enum logic [1:0] {
      ARB   = 2'd0,
      GRANT = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   g;
   logic               has_grant;

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] g_onehot;
   logic [PTR_W-1:0]     sel;
   logic [PTR_W-1:0]     ptr_after_g;
   logic                 found;
   logic                 g_empty;
   logic                 load_g;
   logic                 inc_burst;
   logic                 release_g;
   logic [WORD_WIDTH-1:0] din_sel;

   assign eligible    = port_enable & ~src_empty;
   assign g_onehot    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << g;
   assign g_empty     = src_empty[g] | ~port_enable[g];
   assign ptr_after_g = (g == PTR_W'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
   assign state_dbg   = state;

   // First eligible index at or after ptr, wrapping around.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      sel   = ptr;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && eligible[PTR_W'(idx)]) begin
            found = 1'b1;
            sel   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      din_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (PTR_W'(i) == g) din_sel = src_din[i*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   assign tx_din = has_grant ? din_sel : '0;

   always_comb begin
      state_n   = state;
      grant     = '0;
      tx_empty  = 1'b1;
      src_re    = '0;
      load_g    = 1'b0;
      inc_burst = 1'b0;
      release_g = 1'b0;
      case (state)
         ARB: begin
            if (found) begin
               load_g  = 1'b1;
               state_n = GRANT;
            end
         end
         GRANT: begin
            grant    = g_onehot;
            tx_empty = g_empty;
            if (g_empty) begin
               release_g = 1'b1;
               state_n   = ARB;
            end else if (tx_re) begin
               src_re    = g_onehot;
               inc_burst = 1'b1;
               state_n   = DATA;
            end
         end
         DATA: begin
            grant = g_onehot;
            if (burst_count == BC_W'(MAX_BURST)) begin
               release_g = 1'b1;
               state_n   = ARB;
            end else begin
               state_n = GRANT;
            end
         end
         default: state_n = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB;
         ptr         <= '0;
         g           <= '0;
         burst_count <= '0;
         has_grant   <= 1'b0;
      end else begin
         state <= state_n;
         if (load_g) begin
            g           <= sel;
            burst_count <= '0;
            has_grant   <= 1'b1;
         end
         if (inc_burst) burst_count <= burst_count + 1'b1;
         if (release_g) ptr <= ptr_after_g;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table of directed vectors, then FIFO-backed burst,
// release, reset-in-flight and MAX_BURST=1 round-robin sequences.
module tb_uart_tx_arbiter;
   localparam int W   = 8;
   localparam int N   = 4;
   localparam int MB  = 16;
   localparam int BCW = $clog2(MB + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main DUT
   logic [N-1:0]   pe;
   logic [N-1:0]   src_empty;
   logic [N*W-1:0] src_din;
   logic [N-1:0]   src_re;
   logic           tx_re;
   logic           tx_empty;
   logic [W-1:0]   tx_din;
   logic [N-1:0]   grant;
   logic [BCW-1:0] burst_count;
   logic [1:0]     state_dbg;

   // MAX_BURST=1 DUT, every source always full
   logic           tx_re1;
   logic [N-1:0]   src_re1;
   logic           tx_empty1;
   logic [W-1:0]   tx_din1;
   logic [N-1:0]   grant1;
   logic [0:0]     burst_count1;
   logic [1:0]     state_dbg1;

   logic           fifo_mode;
   logic [N-1:0]   tbl_se;
   logic [N-1:0]   fifo_empty;
   logic [N*W-1:0] fifo_din;
   logic [N*W-1:0] tbl_din;

   assign tbl_din   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   assign src_empty = fifo_mode ? fifo_empty : tbl_se;
   assign src_din   = fifo_mode ? fifo_din : tbl_din;

   uart_tx_arbiter #(.WORD_WIDTH(W), .NUM_PORTS(N), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .port_enable(pe), .src_empty(src_empty), .src_din(src_din),
      .src_re(src_re), .tx_re(tx_re), .tx_empty(tx_empty), .tx_din(tx_din),
      .grant(grant), .burst_count(burst_count), .state_dbg(state_dbg));

   uart_tx_arbiter #(.WORD_WIDTH(W), .NUM_PORTS(N), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst), .port_enable(4'hF), .src_empty(4'h0), .src_din(tbl_din),
      .src_re(src_re1), .tx_re(tx_re1), .tx_empty(tx_empty1), .tx_din(tx_din1),
      .grant(grant1), .burst_count(burst_count1), .state_dbg(state_dbg1));

   // source FIFO models: data valid the cycle after src_re, word = port*64 + index
   int           fifo_cnt[N];
   int           fifo_idx[N];
   logic [W-1:0] fifo_dout[N];
   logic         fifo_load = 1'b0;
   int           load_cnt[N];
   int           fifo_underflow = 0;

   always @(posedge clk) begin
      for (int p = 0; p < N; p++) begin
         if (fifo_load) begin
            fifo_cnt[p] <= load_cnt[p];
            fifo_idx[p] <= 0;
         end else if (fifo_mode && src_re[p]) begin
            if (fifo_cnt[p] > 0) begin
               fifo_dout[p] <= W'(p * 64 + fifo_idx[p]);
               fifo_cnt[p]  <= fifo_cnt[p] - 1;
               fifo_idx[p]  <= fifo_idx[p] + 1;
            end else begin
               fifo_underflow <= fifo_underflow + 1;
            end
         end
      end
   end

   always_comb begin
      fifo_empty = '0;
      fifo_din   = '0;
      for (int p = 0; p < N; p++) begin
         fifo_empty[p]        = (fifo_cnt[p] == 0);
         fifo_din[p*W +: W]   = fifo_dout[p];
      end
   end

   // scoreboard
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic         pending = 1'b0;
   int           words_seen = 0;
   int           max_bc = 0;
   int           re2_pulses = 0;
   logic [N-1:0] grant_or = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      check("src_re_onehot0", 32'($onehot0(src_re)), 1);
      check("src_re_while_empty", src_re & src_empty, 0);
      if (src_re != 0) check("src_re_without_tx_re", tx_re, 1);
      if (src_re[2]) re2_pulses++;
      if (int'(burst_count) > max_bc) max_bc = int'(burst_count);
      grant_or = grant_or | grant;
      if (pending) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", tx_din);
         end else begin
            check("tx_din_word", tx_din, exp_q.pop_front());
         end
         words_seen++;
      end
      pending = tx_re && !tx_empty;
   endtask

   task automatic tick();
      @(negedge clk);
      if (fifo_mode) monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tx_re   = 1'b0;
      tx_re1  = 1'b0;
      pending = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic load(input int c0, input int c1, input int c2, input int c3);
      load_cnt[0] = c0; load_cnt[1] = c1; load_cnt[2] = c2; load_cnt[3] = c3;
      fifo_load = 1'b1;
      @(posedge clk); #1;
      fifo_load = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]   pe;
      logic [N-1:0]   se;
      logic           tre;
      logic [1:0]     st;
      logic [N-1:0]   gr;
      logic           te;
      logic [N-1:0]   sre;
      logic [BCW-1:0] bc;
      logic [W-1:0]   din;
   } vec_t;

   vec_t tbl[21];

   initial begin
      // pe, se, tre | state, grant, tx_empty, src_re, burst_count, tx_din
      tbl[0]  = '{4'hF, 4'hF, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 5'd0, 8'h00};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 5'd0, 8'h00};
      tbl[2]  = '{4'hF, 4'hB, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 5'd0, 8'h00};
      tbl[3]  = '{4'hF, 4'hB, 1'b1, 2'd1, 4'h4, 1'b0, 4'h4, 5'd0, 8'hA2};
      tbl[4]  = '{4'hF, 4'hB, 1'b1, 2'd2, 4'h4, 1'b1, 4'h0, 5'd1, 8'hA2};
      tbl[5]  = '{4'hF, 4'hB, 1'b0, 2'd1, 4'h4, 1'b0, 4'h0, 5'd1, 8'hA2};
      tbl[6]  = '{4'hF, 4'hF, 1'b1, 2'd1, 4'h4, 1'b1, 4'h0, 5'd1, 8'hA2};
      tbl[7]  = '{4'hB, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 5'd1, 8'hA2};
      tbl[8]  = '{4'hB, 4'h0, 1'b1, 2'd1, 4'h8, 1'b0, 4'h8, 5'd0, 8'hA3};
      tbl[9]  = '{4'hB, 4'h0, 1'b0, 2'd2, 4'h8, 1'b1, 4'h0, 5'd1, 8'hA3};
      tbl[10] = '{4'h3, 4'h0, 1'b1, 2'd1, 4'h8, 1'b1, 4'h0, 5'd1, 8'hA3};
      tbl[11] = '{4'hB, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 5'd1, 8'hA3};
      tbl[12] = '{4'hB, 4'h0, 1'b0, 2'd1, 4'h1, 1'b0, 4'h0, 5'd0, 8'hA0};
      tbl[13] = '{4'hA, 4'h0, 1'b1, 2'd1, 4'h1, 1'b1, 4'h0, 5'd0, 8'hA0};
      tbl[14] = '{4'hB, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 5'd0, 8'hA0};
      tbl[15] = '{4'hB, 4'h0, 1'b0, 2'd1, 4'h2, 1'b0, 4'h0, 5'd0, 8'hA1};
      tbl[16] = '{4'hB, 4'h0, 1'b1, 2'd1, 4'h2, 1'b0, 4'h2, 5'd0, 8'hA1};
      tbl[17] = '{4'hB, 4'hF, 1'b0, 2'd2, 4'h2, 1'b1, 4'h0, 5'd1, 8'hA1};
      tbl[18] = '{4'hB, 4'hF, 1'b0, 2'd1, 4'h2, 1'b1, 4'h0, 5'd1, 8'hA1};
      tbl[19] = '{4'hB, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 5'd1, 8'hA1};
      tbl[20] = '{4'hB, 4'h0, 1'b0, 2'd1, 4'h8, 1'b0, 4'h0, 5'd0, 8'hA3};

      fifo_mode = 1'b0;
      pe        = 4'hF;
      tbl_se    = 4'hF;
      do_reset();

      // directed cycle table
      for (int r = 0; r < 21; r++) begin
         pe     = tbl[r].pe;
         tbl_se = tbl[r].se;
         tx_re  = tbl[r].tre;
         @(negedge clk);
         check($sformatf("row%0d_state", r), state_dbg, tbl[r].st);
         check($sformatf("row%0d_grant", r), grant, tbl[r].gr);
         check($sformatf("row%0d_tx_empty", r), tx_empty, tbl[r].te);
         check($sformatf("row%0d_src_re", r), src_re, tbl[r].sre);
         check($sformatf("row%0d_burst_count", r), burst_count, tbl[r].bc);
         check($sformatf("row%0d_tx_din", r), tx_din, tbl[r].din);
         @(posedge clk); #1;
      end

      // two 20-word sources, bursts capped at 16
      fifo_mode = 1'b1;
      pe        = 4'hF;
      do_reset();
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back(W'(k));
      for (int k = 0; k < 16; k++) exp_q.push_back(W'(64 + k));
      for (int k = 16; k < 20; k++) exp_q.push_back(W'(k));
      for (int k = 16; k < 20; k++) exp_q.push_back(W'(64 + k));
      words_seen = 0;
      max_bc     = 0;
      load(20, 20, 0, 0);
      tx_re = 1'b1;
      for (int c = 0; c < 400 && words_seen < 40; c++) tick();
      check("burst_words_seen", words_seen, 40);
      check("burst_queue_drained", exp_q.size(), 0);
      check("burst_count_peak", max_bc, 16);
      check("fifo_underflow", fifo_underflow, 0);

      // single source with three words, then pointer check
      do_reset();
      exp_q.delete();
      for (int k = 0; k < 3; k++) exp_q.push_back(W'(128 + k));
      words_seen = 0;
      re2_pulses = 0;
      grant_or   = '0;
      load(0, 0, 3, 0);
      tx_re = 1'b1;
      for (int c = 0; c < 50 && words_seen < 3; c++) tick();
      for (int c = 0; c < 10 && state_dbg != 2'd0; c++) tick();
      check("single_words_seen", words_seen, 3);
      check("single_src_re2_pulses", re2_pulses, 3);
      check("single_grant_seen", grant_or, 4'h4);
      check("single_released_state", state_dbg, 0);
      check("single_released_grant", grant, 0);
      tx_re = 1'b0;
      load(1, 1, 1, 1);
      for (int c = 0; c < 10 && grant == 0; c++) tick();
      check("ptr_after_release_grant", grant, 4'h8);

      // reset while a read is in flight
      do_reset();
      exp_q.delete();
      exp_q.push_back(W'(64));
      exp_q.push_back(W'(128));
      re2_pulses = 0;
      load(0, 1, 3, 0);
      tx_re = 1'b1;
      for (int c = 0; c < 40 && re2_pulses == 0; c++) tick();
      check("inflight_reached_port2", re2_pulses, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("rst_state", state_dbg, 0);
      check("rst_grant", grant, 0);
      check("rst_src_re", src_re, 0);
      check("rst_tx_empty", tx_empty, 1);
      check("rst_tx_din", tx_din, 0);
      check("rst_burst_count", burst_count, 0);
      check("inflight_queue_drained", exp_q.size(), 0);
      tx_re   = 1'b0;
      pending = 1'b0;
      load(2, 2, 2, 2);
      rst = 1'b0;
      for (int c = 0; c < 10 && grant == 0; c++) tick();
      check("resume_from_port0", grant, 4'h1);

      // MAX_BURST=1 rotation on the second instance
      fifo_mode = 1'b0;
      do_reset();
      tx_re1 = 1'b1;
      begin
         logic [N-1:0] prev;
         int exp_idx;
         int episodes;
         int re_in_ep;
         prev     = '0;
         exp_idx  = 0;
         episodes = 0;
         re_in_ep = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (grant1 != 0 && prev == 0) begin
               if (episodes > 0) check("mb1_words_per_grant", re_in_ep, 1);
               check("mb1_grant_order", grant1, 4'b0001 << exp_idx);
               exp_idx  = (exp_idx + 1) % N;
               episodes++;
               re_in_ep = 0;
            end
            if (src_re1 != 0) re_in_ep++;
            prev = grant1;
            @(posedge clk); #1;
         end
         check("mb1_episode_count", 32'(episodes >= 8), 1);
      end
      tx_re1 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
